// File: rtl/min_max_top.sv
// LED bar-graph controller: thermometer display of val_i inside [min_i, max_i] with an osc tail.
// Optional fault injection (selected by ERRNO) is compiled in only with MIN_MAX_ERRNO_EN.
module min_max_top #(
  parameter int unsigned VALSIZE = 4,
  parameter int unsigned ERRNO   = 0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [1:0]              com_i,
  input  logic [VALSIZE-1:0]      max_i,
  input  logic [VALSIZE-1:0]      min_i,
  input  logic                    osc_i,
  input  logic [VALSIZE-1:0]      val_i,
  output logic [(2**VALSIZE)-1:0] leds_o
);

  localparam int LedW = 2 ** VALSIZE;

`ifdef MIN_MAX_ERRNO_EN
  localparam int unsigned Err = ERRNO;
`else
  localparam int unsigned Err = ERRNO * 0;
`endif

  logic [LedW-1:0] r_leds;
  logic [LedW-1:0] w_next;
  logic [LedW-1:0] w_rst_val;
  logic            w_in_window;
  int              w_min;
  int              w_max;
  int              w_val;

  // Widen to int so the index loop never wraps at val = 2^VALSIZE-1.
  assign w_min       = int'(min_i);
  assign w_max       = int'(max_i);
  assign w_val       = int'(val_i);
  assign w_in_window = (min_i <= val_i) && (val_i <= max_i);
  assign w_rst_val   = (Err == 5) ? '1 : '0;

  always_comb begin
    w_next = '0;
    unique case (com_i)
      2'b00: begin
        if (w_in_window) begin
          for (int i = 0; i < LedW; i++) begin
            if (i >= w_min && i <= w_val) begin
              w_next[i] = !((Err == 1) && (i == w_min));
            end else if (i > w_val && i <= w_max) begin
              w_next[i] = osc_i && (Err != 2);
            end
          end
        end
      end
      2'b01: begin
        for (int i = 0; i < LedW; i++) begin
          if (i <= w_val) begin
            w_next[i] = !((Err == 3) && (i == w_val));
          end
        end
      end
      2'b10: w_next = '0;
      2'b11: begin
        w_next = '1;
        if (Err == 4) begin
          w_next[LedW-1] = 1'b0;
        end
      end
      default: w_next = '0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_leds <= w_rst_val;
    end else begin
      r_leds <= w_next;
    end
  end

  assign leds_o = r_leds;

endmodule

// File: tb/tb_min_max_top.sv
// Self-checking bench for min_max_top (VALSIZE=4): directed vector table, hand sequences and a
// randomized normal-mode run, all checked through an expected-value queue with 1-cycle latency.
module tb_min_max_top;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [1:0]  com_i = 2'b00;
  logic [3:0]  max_i = '0;
  logic [3:0]  min_i = '0;
  logic        osc_i = 1'b0;
  logic [3:0]  val_i = '0;
  logic [15:0] leds_o;

  int tests = 0;
  int fails = 0;

  logic [15:0] exp_q[$];
  string       name_q[$];

  min_max_top #(
    .VALSIZE(4),
    .ERRNO  (0)
  ) dut (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .com_i (com_i),
    .max_i (max_i),
    .min_i (min_i),
    .osc_i (osc_i),
    .val_i (val_i),
    .leds_o(leds_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        rst;
    logic [1:0]  com;
    logic [3:0]  mn;
    logic [3:0]  mx;
    logic [3:0]  v;
    logic        o;
    logic [15:0] exp;
  } vec_t;

  // Mask-based reference: bits [0..n] set.
  function automatic logic [15:0] upto(input int n);
    logic [16:0] m;
    m = (17'd1 << (n + 1)) - 17'd1;
    return m[15:0];
  endfunction

  function automatic logic [15:0] model(input logic [1:0] com, input logic [3:0] mn,
                                        input logic [3:0] mx, input logic [3:0] v,
                                        input logic o);
    logic [15:0] body;
    logic [15:0] tail;
    case (com)
      2'b00: begin
        if (mn > v || v > mx) return 16'h0000;
        body = upto(int'(v)) & ~(upto(int'(mn)) >> 1);
        tail = upto(int'(mx)) & ~upto(int'(v));
        return o ? (body | tail) : body;
      end
      2'b01:   return upto(int'(v));
      2'b10:   return 16'h0000;
      default: return 16'hFFFF;
    endcase
  endfunction

  task automatic drive(input string nm, input logic r, input logic [1:0] c, input logic [3:0] mn,
                       input logic [3:0] mx, input logic [3:0] v, input logic o,
                       input logic [15:0] e);
    logic [15:0] exp_v;
    string       exp_n;
    @(negedge clk_i);
    rst_i = r;
    com_i = c;
    min_i = mn;
    max_i = mx;
    val_i = v;
    osc_i = o;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk_i);
    #1;
    exp_v = exp_q.pop_front();
    exp_n = name_q.pop_front();
    tests++;
    if (leds_o !== exp_v) begin
      fails++;
      $display("FAIL %s: leds_o=0x%04h expected 0x%04h", exp_n, leds_o, exp_v);
    end
  endtask

  vec_t vecs[$];

  initial begin
    logic [3:0] mn;
    logic [3:0] mx;
    logic [3:0] v;
    logic       o;
    int         rst_at;

    vecs.push_back('{"reset_com11",     1'b1, 2'b11, 4'd0, 4'd0,  4'd0,  1'b0, 16'h0000});
    vecs.push_back('{"release_com11",   1'b0, 2'b11, 4'd0, 4'd0,  4'd0,  1'b0, 16'hFFFF});
    vecs.push_back('{"window_osc1",     1'b0, 2'b00, 4'd3, 4'd12, 4'd8,  1'b1, 16'h1FF8});
    vecs.push_back('{"window_osc0",     1'b0, 2'b00, 4'd3, 4'd12, 4'd8,  1'b0, 16'h01F8});
    vecs.push_back('{"val_above_max",   1'b0, 2'b00, 4'd3, 4'd12, 4'd13, 1'b1, 16'h0000});
    vecs.push_back('{"val_below_min",   1'b0, 2'b00, 4'd3, 4'd12, 4'd2,  1'b1, 16'h0000});
    vecs.push_back('{"min_gt_max",      1'b0, 2'b00, 4'd9, 4'd4,  4'd6,  1'b1, 16'h0000});
    vecs.push_back('{"full_val15",      1'b0, 2'b00, 4'd0, 4'd15, 4'd15, 1'b0, 16'hFFFF});
    vecs.push_back('{"min_max_val_7",   1'b0, 2'b00, 4'd7, 4'd7,  4'd7,  1'b1, 16'h0080});
    vecs.push_back('{"val0_osc0",       1'b0, 2'b00, 4'd0, 4'd15, 4'd0,  1'b0, 16'h0001});
    vecs.push_back('{"val0_osc1",       1'b0, 2'b00, 4'd0, 4'd15, 4'd0,  1'b1, 16'hFFFF});
    vecs.push_back('{"linear_val5",     1'b0, 2'b01, 4'd9, 4'd12, 4'd5,  1'b1, 16'h003F});
    vecs.push_back('{"linear_val15",    1'b0, 2'b01, 4'd0, 4'd0,  4'd15, 1'b0, 16'hFFFF});
    vecs.push_back('{"all_off",         1'b0, 2'b10, 4'd0, 4'd15, 4'd8,  1'b1, 16'h0000});
    vecs.push_back('{"all_on",          1'b0, 2'b11, 4'd0, 4'd15, 4'd8,  1'b1, 16'hFFFF});

    foreach (vecs[k]) begin
      drive(vecs[k].name, vecs[k].rst, vecs[k].com, vecs[k].mn, vecs[k].mx, vecs[k].v,
            vecs[k].o, vecs[k].exp);
    end

    // Reset mid-operation, then the first edge after release loads from current inputs.
    drive("pre_reset",      1'b0, 2'b00, 4'd2, 4'd10, 4'd5, 1'b1, 16'h07FC);
    drive("mid_reset",      1'b1, 2'b00, 4'd2, 4'd10, 4'd5, 1'b1, 16'h0000);
    drive("post_reset",     1'b0, 2'b00, 4'd2, 4'd10, 4'd5, 1'b0, 16'h003C);
    // osc toggling only changes the tail, one cycle later.
    drive("osc_tail_on",    1'b0, 2'b00, 4'd2, 4'd10, 4'd5, 1'b1, 16'h07FC);
    drive("osc_tail_off",   1'b0, 2'b00, 4'd2, 4'd10, 4'd5, 1'b0, 16'h003C);

    rst_at = 500;
    for (int n = 0; n < 1200; n++) begin
      mn = 4'($urandom_range(0, 14));
      mx = 4'($urandom_range(int'(mn) + 1, 15));
      v  = 4'($urandom_range(int'(mn), int'(mx)));
      o  = 1'($urandom_range(0, 1));
      if (n == rst_at) begin
        drive("rand_reset", 1'b1, 2'b00, mn, mx, v, o, 16'h0000);
      end else begin
        drive("rand_normal", 1'b0, 2'b00, mn, mx, v, o, model(2'b00, mn, mx, v, o));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
